// File: rtl/hamming_dec_ctrl.sv
// hamming_dec_ctrl
// Batch SECDED decoder that owns the data memory while busy. For each word it
// reads a 16-bit codeword as two bytes, corrects single-bit errors, flags
// double-bit errors, and writes the 11-bit payload plus a 2-bit status flag
// back as two bytes. Outputs are decoded from registered state and registers
// only, so memory ports never see a combinational path from i_mem_rdata.

module hamming_dec_ctrl #(
   parameter int W        = 8,
   parameter int ADDR_W   = 8,
   parameter int IN_BASE  = 64,
   parameter int OUT_BASE = 0,
   parameter int N_WORDS  = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   output logic              o_ack,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_raddr,
   input  logic [W-1:0]      i_mem_rdata,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [W-1:0]      o_wdata,
   output logic [3:0]        o_single_cnt,
   output logic [3:0]        o_double_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_DEC,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
   localparam logic [3:0]        LAST_IDX   = 4'(N_WORDS - 1);

   state_t r_state;
   state_t w_nextState;

   logic [3:0]        r_wordIdx;
   logic [15:0]       r_cw;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] r_waddr;
   logic [W-1:0]      r_wdata;
   logic [7:0]        r_hiByte;
   logic [3:0]        r_singleCnt;
   logic [3:0]        r_doubleCnt;

   logic [ADDR_W-1:0] w_inAddrLo;
   logic [ADDR_W-1:0] w_inAddrNext;
   logic [ADDR_W-1:0] w_outAddrLo;
   logic [3:0]        w_idxNext;
   logic              w_lastWord;

   logic [3:0]        w_syn;
   logic              w_par;
   logic [15:0]       w_corr;
   logic [1:0]        w_flag;
   logic [7:0]        w_loByte;
   logic [7:0]        w_hiByte;

   // Byte addresses for the current and next word; arithmetic wraps at 2^ADDR_W.
   assign w_idxNext    = r_wordIdx + 4'd1;
   assign w_inAddrLo   = IN_BASE_A + ADDR_W'({r_wordIdx, 1'b0});
   assign w_inAddrNext = IN_BASE_A + ADDR_W'({w_idxNext, 1'b0});
   assign w_outAddrLo  = OUT_BASE_A + ADDR_W'({r_wordIdx, 1'b0});
   assign w_lastWord   = (r_wordIdx >= LAST_IDX);

   // SECDED decode of the latched codeword: syndrome is the XOR of set-bit
   // positions, overall parity covers all 16 bits. Only a single error with a
   // nonzero syndrome needs a bit flipped; an error in bit 0 leaves data intact.
   always_comb begin
      w_syn  = 4'd0;
      for (int p = 0; p < 16; p++) begin
         if (r_cw[p]) begin
            w_syn = w_syn ^ 4'(p);
         end
      end
      w_par  = ^r_cw;
      w_corr = r_cw;
      if (w_par && (w_syn != 4'd0)) begin
         w_corr[w_syn] = ~r_cw[w_syn];
      end
      if (w_par) begin
         w_flag = 2'b01;
      end else if (w_syn != 4'd0) begin
         w_flag = 2'b10;
      end else begin
         w_flag = 2'b00;
      end
      w_loByte = {w_corr[12], w_corr[11], w_corr[10], w_corr[9],
                  w_corr[7],  w_corr[6],  w_corr[5],  w_corr[3]};
      w_hiByte = {w_flag, 3'b000, w_corr[15], w_corr[14], w_corr[13]};
   end

   // State register; reset forces IDLE so the write strobe drops at that edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: fixed five-cycle sequence per word, req only matters
   // in IDLE (start) and DONE (release).
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         S_IDLE:  if (i_req) w_nextState = S_RD_LO;
         S_RD_LO: w_nextState = S_RD_HI;
         S_RD_HI: w_nextState = S_DEC;
         S_DEC:   w_nextState = S_WR_LO;
         S_WR_LO: w_nextState = S_WR_HI;
         S_WR_HI: w_nextState = w_lastWord ? S_DONE : S_RD_LO;
         S_DONE:  if (!i_req) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Datapath registers. Address and data registers are loaded one state ahead
   // so they are stable for the whole cycle in which the memory uses them.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wordIdx   <= 4'd0;
         r_cw        <= 16'd0;
         r_raddr     <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_hiByte    <= 8'd0;
         r_singleCnt <= 4'd0;
         r_doubleCnt <= 4'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_wordIdx   <= 4'd0;
                  r_singleCnt <= 4'd0;
                  r_doubleCnt <= 4'd0;
                  r_raddr     <= IN_BASE_A;
               end
            end
            S_RD_LO: begin
               r_cw[7:0] <= i_mem_rdata[7:0];
               r_raddr   <= w_inAddrLo + ONE_A;
            end
            S_RD_HI: begin
               r_cw[15:8] <= i_mem_rdata[7:0];
            end
            S_DEC: begin
               r_waddr  <= w_outAddrLo;
               r_wdata  <= W'(w_loByte);
               r_hiByte <= w_hiByte;
               if ((w_flag == 2'b01) && (r_singleCnt != 4'hF)) begin
                  r_singleCnt <= r_singleCnt + 4'd1;
               end
               if ((w_flag == 2'b10) && (r_doubleCnt != 4'hF)) begin
                  r_doubleCnt <= r_doubleCnt + 4'd1;
               end
            end
            S_WR_LO: begin
               r_waddr <= w_outAddrLo + ONE_A;
               r_wdata <= W'(r_hiByte);
            end
            S_WR_HI: begin
               r_wordIdx <= w_idxNext;
               if (!w_lastWord) begin
                  r_raddr <= w_inAddrNext;
               end
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
   assign o_ack        = (r_state == S_DONE);
   assign o_write_en   = (r_state == S_WR_LO) || (r_state == S_WR_HI);
   assign o_raddr      = r_raddr;
   assign o_waddr      = r_waddr;
   assign o_wdata      = r_wdata;
   assign o_single_cnt = r_singleCnt;
   assign o_double_cnt = r_doubleCnt;

endmodule

// File: tb/tb_hamming_dec_ctrl.sv
// tb_hamming_dec_ctrl
// Directed bench: a table of hand-decoded codewords run through a 15-word
// instance with a byte memory model, plus sequences for reset mid-run, req held
// across DONE, and a single-word instance whose addresses wrap.

module tb_hamming_dec_ctrl;

   typedef struct {
      logic [15:0] cw;
      logic [7:0]  expLo;
      logic [7:0]  expHi;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic req1, req2;

   logic       ack1, busy1, we1;
   logic [7:0] raddr1, rdata1, waddr1, wdata1;
   logic [3:0] sc1, dc1;

   logic       ack2, busy2, we2;
   logic [7:0] raddr2, rdata2, waddr2, wdata2;
   logic [3:0] sc2, dc2;

   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];

   logic       tbWe;
   logic       tbSel;
   logic [7:0] tbAddr;
   logic [7:0] tbData;

   logic [7:0] wlogAddr [4];
   logic [7:0] wlogData [4];
   int         wlogCount = 0;

   vec_t vecs [15];
   int   nChecks = 0;
   int   nFails  = 0;

   hamming_dec_ctrl #(.W(8), .ADDR_W(8), .IN_BASE(64), .OUT_BASE(0), .N_WORDS(15)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_req(req1), .o_ack(ack1), .o_busy(busy1),
      .o_raddr(raddr1), .i_mem_rdata(rdata1), .o_write_en(we1), .o_waddr(waddr1),
      .o_wdata(wdata1), .o_single_cnt(sc1), .o_double_cnt(dc1)
   );

   hamming_dec_ctrl #(.W(8), .ADDR_W(8), .IN_BASE(254), .OUT_BASE(255), .N_WORDS(1)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_req(req2), .o_ack(ack2), .o_busy(busy2),
      .o_raddr(raddr2), .i_mem_rdata(rdata2), .o_write_en(we2), .o_waddr(waddr2),
      .o_wdata(wdata2), .o_single_cnt(sc2), .o_double_cnt(dc2)
   );

   assign rdata1 = mem1[raddr1];
   assign rdata2 = mem2[raddr2];

   // Memory models: bench preload port plus each DUT's write port; DUT2 writes are logged.
   always @(posedge clk) begin
      if (tbWe) begin
         if (tbSel) mem2[tbAddr] <= tbData;
         else       mem1[tbAddr] <= tbData;
      end
      if (we1) mem1[waddr1] <= wdata1;
      if (we2) begin
         mem2[waddr2] <= wdata2;
         if (wlogCount < 4) begin
            wlogAddr[wlogCount] <= waddr2;
            wlogData[wlogCount] <= wdata2;
         end
         wlogCount <= wlogCount + 1;
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic memWrite(input logic sel, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tbSel  = sel;
      tbAddr = a;
      tbData = d;
      tbWe   = 1'b1;
      @(negedge clk);
      tbWe   = 1'b0;
   endtask

   function automatic logic [15:0] wordFor(input bit useTable, input int k);
      if (useTable) return vecs[k].cw;
      return (k % 2 == 1) ? 16'hFFFF : 16'h0000;
   endfunction

   // Preload 15 codewords at 64.. and poison the result area.
   task automatic loadWords(input bit useTable);
      logic [15:0] cw;
      for (int k = 0; k < 15; k++) begin
         cw = wordFor(useTable, k);
         memWrite(1'b0, 8'(64 + 2 * k), cw[7:0]);
         memWrite(1'b0, 8'(65 + 2 * k), cw[15:8]);
         memWrite(1'b0, 8'(2 * k), 8'h55);
         memWrite(1'b0, 8'(2 * k + 1), 8'h55);
      end
   endtask

   task automatic checkResults(input bit useTable, input string tag);
      logic [7:0] lo, hi;
      for (int k = 0; k < 15; k++) begin
         if (useTable) begin
            lo = vecs[k].expLo;
            hi = vecs[k].expHi;
         end else begin
            lo = (k % 2 == 1) ? 8'hFF : 8'h00;
            hi = (k % 2 == 1) ? 8'h07 : 8'h00;
         end
         checkOutput($sformatf("%s_lo%0d", tag, k), 32'(mem1[2 * k]), 32'(lo));
         checkOutput($sformatf("%s_hi%0d", tag, k), 32'(mem1[2 * k + 1]), 32'(hi));
      end
   endtask

   // Start a run on DUT1 and count edges from the start edge until ack is seen.
   task automatic applyStimulus(output int latency, output logic [3:0] scStart,
                                output logic [3:0] dcStart, output logic busyStart);
      latency   = -1;
      scStart   = 4'hx;
      dcStart   = 4'hx;
      busyStart = 1'bx;
      @(negedge clk);
      req1 = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            scStart   = sc1;
            dcStart   = dc1;
            busyStart = busy1;
         end
         if (ack1) begin
            latency = n;
            break;
         end
      end
   endtask

   task automatic releaseReq1(input string tag);
      @(negedge clk);
      req1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_ackAfterDrop"}, 32'(ack1), 32'd0);
      checkOutput({tag, "_busyAfterDrop"}, 32'(busy1), 32'd0);
   endtask

   initial begin
      int         lat;
      int         expSingle;
      int         expDouble;
      logic [3:0] scS, dcS;
      logic       busyS;

      vecs[0]  = '{16'h0000, 8'h00, 8'h00};
      vecs[1]  = '{16'hFFFF, 8'hFF, 8'h07};
      vecs[2]  = '{16'h0020, 8'h00, 8'h40};
      vecs[3]  = '{16'h0001, 8'h00, 8'h40};
      vecs[4]  = '{16'h0030, 8'h02, 8'h80};
      vecs[5]  = '{16'h000F, 8'h01, 8'h00};
      vecs[6]  = '{16'h8117, 8'h00, 8'h04};
      vecs[7]  = '{16'h8317, 8'h00, 8'h44};
      vecs[8]  = '{16'h800F, 8'h01, 8'h40};
      vecs[9]  = '{16'h1007, 8'h80, 8'h80};
      vecs[10] = '{16'hFF7F, 8'hFF, 8'h47};
      vecs[11] = '{16'h0003, 8'h00, 8'h80};
      vecs[12] = '{16'h0100, 8'h00, 8'h40};
      vecs[13] = '{16'hFFFE, 8'hFF, 8'h47};
      vecs[14] = '{16'h0011, 8'h00, 8'h80};

      expSingle = 0;
      expDouble = 0;
      for (int k = 0; k < 15; k++) begin
         if (vecs[k].expHi[7:6] == 2'b01) expSingle++;
         if (vecs[k].expHi[7:6] == 2'b10) expDouble++;
      end

      reset = 1'b1;
      req1  = 1'b0;
      req2  = 1'b0;
      tbWe  = 1'b0;
      tbSel = 1'b0;
      tbAddr = 8'd0;
      tbData = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ack", 32'(ack1), 32'd0);
      checkOutput("rst_busy", 32'(busy1), 32'd0);
      checkOutput("rst_we", 32'(we1), 32'd0);
      checkOutput("rst_raddr", 32'(raddr1), 32'd0);
      checkOutput("rst_waddr", 32'(waddr1), 32'd0);
      checkOutput("rst_wdata", 32'(wdata1), 32'd0);
      checkOutput("rst_single", 32'(sc1), 32'd0);
      checkOutput("rst_double", 32'(dc1), 32'd0);
      checkOutput("rst_waddr2", 32'(waddr2), 32'd0);
      reset = 1'b0;

      $display("[TB] all-zero / all-one codewords");
      loadWords(1'b0);
      applyStimulus(lat, scS, dcS, busyS);
      checkOutput("A_ackLatency", 32'(lat), 32'd75);
      checkOutput("A_busyStart", 32'(busyS), 32'd1);
      checkOutput("A_single", 32'(sc1), 32'd0);
      checkOutput("A_double", 32'(dc1), 32'd0);
      checkOutput("A_busyDone", 32'(busy1), 32'd0);
      checkResults(1'b0, "A");
      releaseReq1("A");

      $display("[TB] table of decoded codewords");
      loadWords(1'b1);
      applyStimulus(lat, scS, dcS, busyS);
      checkOutput("B_ackLatency", 32'(lat), 32'd75);
      checkOutput("B_single", 32'(sc1), 32'(expSingle));
      checkOutput("B_double", 32'(dc1), 32'(expDouble));
      checkOutput("B_raddrHold", 32'(raddr1), 32'd93);
      checkResults(1'b1, "B");

      $display("[TB] req held across DONE");
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("hold_ack", 32'(ack1), 32'd1);
      checkOutput("hold_busy", 32'(busy1), 32'd0);
      checkOutput("hold_single", 32'(sc1), 32'(expSingle));
      releaseReq1("hold");

      $display("[TB] restart clears counts");
      applyStimulus(lat, scS, dcS, busyS);
      checkOutput("C_singleStart", 32'(scS), 32'd0);
      checkOutput("C_doubleStart", 32'(dcS), 32'd0);
      checkOutput("C_ackLatency", 32'(lat), 32'd75);
      checkOutput("C_single", 32'(sc1), 32'(expSingle));
      releaseReq1("C");

      $display("[TB] reset in the middle of word 7");
      for (int k = 0; k < 30; k++) memWrite(1'b0, 8'(k), 8'hAA);
      @(negedge clk);
      req1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req1 = 1'b0;
      repeat (38) @(posedge clk);
      @(negedge clk);
      checkOutput("D_weWord7", 32'(we1), 32'd1);
      checkOutput("D_waddrWord7", 32'(waddr1), 32'd14);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("D_weAfterReset", 32'(we1), 32'd0);
      checkOutput("D_busyAfterReset", 32'(busy1), 32'd0);
      checkOutput("D_ackAfterReset", 32'(ack1), 32'd0);
      checkOutput("D_singleAfterReset", 32'(sc1), 32'd0);
      checkOutput("D_waddrAfterReset", 32'(waddr1), 32'd0);
      checkOutput("D_word6Hi", 32'(mem1[13]), 32'(vecs[6].expHi));
      checkOutput("D_word8Untouched", 32'(mem1[16]), 32'hAA);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("D_stillIdle", 32'(busy1), 32'd0);

      $display("[TB] rerun after reset");
      applyStimulus(lat, scS, dcS, busyS);
      checkOutput("E_ackLatency", 32'(lat), 32'd75);
      checkOutput("E_single", 32'(sc1), 32'(expSingle));
      checkOutput("E_double", 32'(dc1), 32'(expDouble));
      checkResults(1'b1, "E");
      releaseReq1("E");

      $display("[TB] single word with address wrap");
      memWrite(1'b1, 8'hFE, 8'h20);
      memWrite(1'b1, 8'hFF, 8'h00);
      @(negedge clk);
      req2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("F_raddrLo", 32'(raddr2), 32'hFE);
      lat = -1;
      for (int n = 1; n <= 50; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) checkOutput("F_raddrHi", 32'(raddr2), 32'hFF);
         if (ack2) begin
            lat = n;
            break;
         end
      end
      checkOutput("F_ackLatency", 32'(lat), 32'd5);
      checkOutput("F_writeCount", 32'(wlogCount), 32'd2);
      checkOutput("F_wr0Addr", 32'(wlogAddr[0]), 32'hFF);
      checkOutput("F_wr0Data", 32'(wlogData[0]), 32'h00);
      checkOutput("F_wr1Addr", 32'(wlogAddr[1]), 32'h00);
      checkOutput("F_wr1Data", 32'(wlogData[1]), 32'h40);
      checkOutput("F_single", 32'(sc2), 32'd1);
      @(negedge clk);
      req2 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("F_ackAfterDrop", 32'(ack2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/hamming_dec_ctrl.md
# hamming_dec_ctrl

Sequencer that drives the `dat_mem` read and write ports to batch-decode Hamming SECDED codewords in place in data memory. On a `req`/`ack` handshake it reads N_WORDS 16-bit codewords as byte pairs starting at IN_BASE, then for each codeword:
- corrects single-bit errors and flags double-bit errors;
- writes the 11-bit payload plus status flags as byte pairs starting at OUT_BASE.

It sits beside `dat_mem` in `top_level` and is the only master of that memory while it is busy.

## Interface
- W, 8: memory data width (fixed at 8 for this block).
- ADDR_W, 8: memory address width.
- IN_BASE, 64: byte address of the first codeword (low byte at even offset).
- OUT_BASE, 0: byte address of the first decoded result.
- N_WORDS, 15: codewords per run (1..15).

- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request, level-sampled in IDLE.
- ack  out  1  run complete; held until `req` is low.
- busy  out  1  high in every state except IDLE and DONE.
- raddr  out  ADDR_W  memory read pointer.
- mem_rdata  in  W  memory combinational read data (`data_out`).
- write_en  out  1  memory write strobe.
- waddr  out  ADDR_W  memory write pointer.
- wdata  out  W  memory write data (`data_in`).
- single_cnt  out  4  number of corrected words (flag 01) in the last run.
- double_cnt  out  4  number of uncorrectable words (flag 10) in the last run.

## Operation
- **Reset values:**
  - state goes to IDLE;
  - `ack`, `busy`, `write_en` = 0;
  - `raddr`, `waddr`, `wdata` = 0;
  - both counts = 0;
  - word index i = 0.
- **Outputs** are Moore-decoded from registered state and registers.
- **FSM:** IDLE → RD_LO → RD_HI → DEC → WR_LO → WR_HI → (RD_LO if i < N_WORDS-1, else DONE) → IDLE.
  - IDLE: when `req` = 1, clear i and both counts, then go to RD_LO.
  - RD_LO: `raddr` = IN_BASE+2i; latch `mem_rdata` into cw[7:0].
  - RD_HI: `raddr` = IN_BASE+2i+1; latch `mem_rdata` into cw[15:8].
  - DEC: compute the result and register lo/hi bytes and the flag. Increment the matching count, saturating at 15.
  - WR_LO: `write_en` = 1, `waddr` = OUT_BASE+2i, `wdata` = lo.
  - WR_HI: `write_en` = 1, `waddr` = OUT_BASE+2i+1, `wdata` = hi; increment i.
  - DONE: `ack` = 1; return to IDLE when `req` = 0.
- **Codeword layout:**
  - Bit p of cw is position p (0..15).
  - Parity bits sit at positions 0 (overall), 1, 2, 4 and 8.
  - Data d1..d11 sit at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15.
- **Decode:**
  - S = XOR of all positions p with cw[p] = 1 (4 bits).
  - P = XOR of all 16 bits.
  - S=0, P=0: clean, flag 00.
  - P=1: single error, flag 01. If S≠0, invert cw[S] before extraction; if S=0 the error is in bit 0 and data is intact.
  - S≠0, P=0: double error, flag 10. Data is extracted from the raw codeword.
- **Result bytes:**
  - lo = {d8..d1}.
  - hi = {flag[1:0], 3'b000, d11, d10, d9}.
- **Address arithmetic** is modulo 2^ADDR_W; wrap-around is allowed, not flagged.
- `req` is ignored outside IDLE and DONE. Dropping `req` mid-run does not abort the run.
- `reset` mid-run:
  - returns to IDLE at that edge;
  - `write_en` is low from that edge on;
  - partial results already written remain in memory.
- Counts hold their values after DONE until the next start.

## Timing
- `req` is sampled high in IDLE at edge T.
- Word k occupies edges T+5k+1 .. T+5k+5.
- Writes for word k occur in the cycles following edges T+5k+3 (lo) and T+5k+4 (hi).
- `ack` rises at edge T+5·N_WORDS (T+75 by default).
- `busy` rises at T and falls at T+5·N_WORDS.
- In DONE with `req` already low, the FSM is in IDLE one edge later. `ack` is high for at least one cycle.
- A read and a write never occur in the same cycle. `raddr` holds its last value outside the RD states.
- Throughput: 5 cycles per word; no pipelining between words.

## Test plan
- Reset mid-run at word 7 → `write_en` = 0 from the next cycle; FSM idle with `ack` = 0; a subsequent `req` reruns from word 0 with counts restarting at 0.
- Codewords 16'h0000 and 16'hFFFF at IN_BASE → (00, 00) and (FF, 07); both counts = 0; `ack` at T+75 for 15 words.
- Codeword 16'h0020 (bit 5 flipped) → lo = 00, hi = 40; `single_cnt` = 1. Codeword 16'h0001 (bit 0 flipped) → lo = 00, hi = 40.
- Codeword 16'h0030 (bits 4 and 5 flipped) → lo = 02, hi = 80; `double_cnt` = 1.
- `req` held high across DONE → `ack` stays 1 and no new run starts. Drop `req` → IDLE next edge. Reassert `req` → new run; counts cleared.
- N_WORDS = 1, IN_BASE = 8'hFE, OUT_BASE = 8'hFF → reads FE, FF; writes FF then 00 (wrap); `ack` at T+5.
